// File: rtl/xorshift256p_checker.sv
// rtl/xorshift256p_checker.sv - xorshift256+ output stream checker with lock tracking
module xorshift256p_checker #(
  parameter int MAX_MISS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [255:0]     seed,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             locked,
  output logic             fail,
  output logic             mismatch,
  output logic             seed_err,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      sample_count,
  output logic [63:0]      expected
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t      state;
  logic [63:0] s0, s1, s2, s3;
  logic [7:0]  miss_cnt;

  logic        accept;
  logic [63:0] cur_sum;
  logic [63:0] t, a0, a1, a2, a3, b2, b3;
  logic [7:0]  miss_next;

  // Seed always takes priority over a sample in the same cycle.
  assign in_ready  = (state == ST_RUN) & ~seed_valid;
  assign accept    = in_valid & in_ready;
  assign locked    = (state == ST_RUN);
  assign fail      = (state == ST_FAIL);
  assign cur_sum   = s0 + s3;
  assign miss_next = miss_cnt + 8'd1;

  // One generator step, each line building on the previous one.
  always_comb begin
    t  = s1 << 17;
    a2 = s2 ^ s0;
    a3 = s3 ^ s1;
    a1 = s1 ^ a2;
    a0 = s0 ^ a3;
    b2 = a2 ^ t;
    b3 = {a3[18:0], a3[63:19]};
  end

  // Seed load, sample compare, counters and state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      s0           <= '0;
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      miss_cnt     <= '0;
      mismatch     <= 1'b0;
      seed_err     <= 1'b0;
      error        <= 1'b0;
      err_count    <= '0;
      sample_count <= '0;
      expected     <= '0;
    end else begin
      mismatch <= 1'b0;
      seed_err <= 1'b0;
      if (seed_valid) begin
        if (seed != 256'd0) begin
          s0           <= seed[63:0];
          s1           <= seed[127:64];
          s2           <= seed[191:128];
          s3           <= seed[255:192];
          expected     <= seed[63:0] + seed[255:192];
          state        <= ST_RUN;
          miss_cnt     <= '0;
          error        <= 1'b0;
          err_count    <= '0;
          sample_count <= '0;
        end else begin
          seed_err <= 1'b1;
        end
      end else if (accept) begin
        s0           <= a0;
        s1           <= a1;
        s2           <= b2;
        s3           <= b3;
        expected     <= a0 + b3;
        sample_count <= sample_count + 32'd1;
        if (in_data != cur_sum) begin
          mismatch <= 1'b1;
          error    <= 1'b1;
          if (err_count != {CNT_W{1'b1}})
            err_count <= err_count + CNT_W'(1);
          miss_cnt <= miss_next;
          if (miss_next == 8'(MAX_MISS))
            state <= ST_FAIL;
        end else begin
          miss_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xorshift256p_checker.sv
// tb/tb_xorshift256p_checker.sv - self-checking bench for xorshift256p_checker
module tb_xorshift256p_checker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_valid = 1'b0;
  logic [255:0] seed = '0;
  logic         in_valid = 1'b0;
  logic [63:0]  in_data = '0;

  logic         in_ready, locked, fail, mismatch, seed_err, error;
  logic [15:0]  err_count;
  logic [31:0]  sample_count;
  logic [63:0]  expected;

  logic         b_in_ready, b_locked, b_fail, b_mismatch, b_seed_err, b_error;
  logic [1:0]   b_err_count;
  logic [31:0]  b_sample_count;
  logic [63:0]  b_expected;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [63:0] m_s [4];
  int          m_state;       // 0 idle, 1 run, 2 fail
  bit          m_mis, m_serr, m_err;
  int unsigned m_errc, m_samp;
  int          m_miss;

  localparam logic [255:0] KNOWN = {64'd4, 64'd3, 64'd2, 64'd1};

  always #5 clk = ~clk;

  xorshift256p_checker #(.MAX_MISS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .locked(locked), .fail(fail), .mismatch(mismatch), .seed_err(seed_err),
    .error(error), .err_count(err_count), .sample_count(sample_count),
    .expected(expected)
  );

  xorshift256p_checker #(.MAX_MISS(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .locked(b_locked), .fail(b_fail), .mismatch(b_mismatch), .seed_err(b_seed_err),
    .error(b_error), .err_count(b_err_count), .sample_count(b_sample_count),
    .expected(b_expected)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_exp();
    return m_s[0] + m_s[3];
  endfunction

  function automatic void model_step();
    logic [63:0] t;
    t = m_s[1] << 17;
    m_s[2] = m_s[2] ^ m_s[0];
    m_s[3] = m_s[3] ^ m_s[1];
    m_s[1] = m_s[1] ^ m_s[2];
    m_s[0] = m_s[0] ^ m_s[3];
    m_s[2] = m_s[2] ^ t;
    m_s[3] = (m_s[3] << 45) | (m_s[3] >> 19);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_s[i] = '0;
    m_state = 0; m_mis = 0; m_serr = 0; m_err = 0;
    m_errc = 0; m_samp = 0; m_miss = 0;
  endfunction

  task automatic check_all();
    chk("locked", locked, m_state == 1);
    chk("fail", fail, m_state == 2);
    chk("mismatch", mismatch, m_mis);
    chk("seed_err", seed_err, m_serr);
    chk("error", error, m_err);
    chk("err_count", err_count, (m_errc > 65535) ? 65535 : m_errc);
    chk("err_count_w2", b_err_count, (m_errc > 3) ? 3 : m_errc);
    chk("sample_count", sample_count, m_samp);
    chk("expected", expected, m_exp());
  endtask

  task automatic cycle(input logic r, input logic sv, input logic [255:0] sd,
                       input logic iv, input logic [63:0] id);
    bit acc;
    logic [63:0] e;
    @(negedge clk);
    rst = r; seed_valid = sv; seed = sd; in_valid = iv; in_data = id;
    #1;
    chk("in_ready", in_ready, (m_state == 1) && !sv);
    acc = iv && (m_state == 1) && !sv;
    @(posedge clk);
    m_mis = 0; m_serr = 0;
    if (r) begin
      model_reset();
    end else if (sv) begin
      if (sd != 256'd0) begin
        for (int i = 0; i < 4; i++) m_s[i] = sd[64*i +: 64];
        m_state = 1; m_err = 0; m_errc = 0; m_samp = 0; m_miss = 0;
      end else begin
        m_serr = 1;
      end
    end else if (acc) begin
      e = m_exp();
      model_step();
      m_samp++;
      if (id != e) begin
        m_mis = 1; m_err = 1; m_errc++; m_miss++;
        if (m_miss >= 4) m_state = 2;
      end else begin
        m_miss = 0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic sample(input bit good);
    cycle(0, 0, '0, 1, good ? m_exp() : (m_exp() ^ 64'h1));
  endtask

  initial begin
    logic [255:0] rs;
    logic [63:0]  d;
    bit sv, iv, r;
    model_reset();

    // reset
    cycle(1, 0, '0, 0, '0);
    cycle(1, 0, '0, 1, 64'h5);
    chk("rst_expected", expected, 64'h0);

    // known sequence
    cycle(0, 1, KNOWN, 0, '0);
    chk("known_exp0", expected, 64'h5);
    cycle(0, 0, '0, 1, 64'h5);
    chk("known_exp1", expected, 64'h0000C00000000007);
    cycle(0, 0, '0, 1, 64'h0000C00000000007);
    chk("known_count", sample_count, 32'd2);
    chk("known_locked", locked, 1'b1);
    chk("known_nomis", error, 1'b0);

    // zero seed after reset
    cycle(1, 0, '0, 0, '0);
    cycle(0, 1, 256'd0, 0, '0);
    chk("zero_seed_err", seed_err, 1'b1);
    chk("zero_idle", locked, 1'b0);
    cycle(0, 0, '0, 1, 64'h5);
    chk("zero_pulse_end", seed_err, 1'b0);
    chk("zero_dropped", sample_count, 32'd0);

    // single error
    cycle(0, 1, KNOWN, 0, '0);
    sample(1); sample(1); sample(0);
    chk("single_mis", mismatch, 1'b1);
    chk("single_errc", err_count, 16'd1);
    sample(1);
    chk("single_mis_clr", mismatch, 1'b0);
    chk("single_locked", locked, 1'b1);
    chk("single_error", error, 1'b1);

    // loss of lock
    for (int i = 0; i < 4; i++) sample(0);
    chk("lol_fail", fail, 1'b1);
    chk("lol_errc", err_count, 16'd5);
    cycle(0, 1, KNOWN, 0, '0);
    for (int i = 0; i < 4; i++) sample(0);
    chk("lol_fail2", fail, 1'b1);
    chk("lol_errc2", err_count, 16'd4);
    sample(1);
    chk("lol_in_ready", in_ready, 1'b0);
    chk("lol_hold", sample_count, 32'd4);
    cycle(0, 1, KNOWN, 0, '0);
    chk("lol_relock", locked, 1'b1);
    chk("lol_clr_err", err_count, 16'd0);
    chk("lol_clr_samp", sample_count, 32'd0);

    // seed/sample collision
    sample(1);
    cycle(0, 1, {64'd40, 64'd30, 64'd20, 64'd10}, 1, 64'h5);
    chk("coll_samp", sample_count, 32'd0);
    chk("coll_exp", expected, 64'd50);

    // random stream
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 149) == 0);
      sv = ($urandom_range(0, 24) == 0) || (m_state != 1 && $urandom_range(0, 3) == 0);
      rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 4) == 0) rs = '0;
      iv = ($urandom_range(0, 3) != 0);
      d  = m_exp();
      if ($urandom_range(0, 4) == 0) d = d ^ {$urandom, $urandom | 32'd1};
      cycle(r, sv, rs, iv, d);
    end

    // saturation with CNT_W=2
    cycle(0, 1, KNOWN, 0, '0);
    for (int i = 0; i < 6; i++) begin
      sample(0);
      sample(1);
    end
    chk("sat_w2", b_err_count, 2'd3);
    chk("sat_w16", err_count, 16'd6);
    chk("sat_locked", locked, 1'b1);

    // reset mid-stream
    cycle(1, 0, '0, 1, m_exp());
    chk("mid_rst_samp", sample_count, 32'd0);
    chk("mid_rst_err", error, 1'b0);
    chk("mid_rst_exp", expected, 64'h0);
    chk("mid_rst_locked", locked, 1'b0);
    cycle(0, 0, '0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xorshift256p_checker.md
# xorshift256p_checker

Stream checker for the xorshift256+ generator output. It holds its own copy of the 256-bit generator state, loaded from the same seed the generator receives, and compares every 64-bit sample it accepts against the expected value. It reports mismatches, keeps counts, and declares loss of lock after too many consecutive errors. It sits on the consuming end of the generator's output port, in self-checking benches and in on-chip built-in self-test (BIST) paths.

## Interface
- `MAX_MISS`, default 4: consecutive mismatches that force FAIL (range 1..255).
- `CNT_W`, default 16: width of `err_count`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seed_valid` in 1: load `seed` this cycle.
- `seed` in 256: {s3,s2,s1,s0}, each 64 bits, s0 in [63:0].
- `in_valid` in 1: `in_data` holds a generator sample.
- `in_data` in 64: sample under test.
- `in_ready` out 1: checker accepts a sample this cycle.
- `locked` out 1: state is RUN.
- `fail` out 1: state is FAIL.
- `mismatch` out 1: one-cycle pulse; the previous accepted sample was wrong.
- `seed_err` out 1: one-cycle pulse; an all-zero seed was rejected.
- `error` out 1: sticky; at least one mismatch since the last seed load.
- `err_count` out CNT_W: total mismatches since the last seed load; saturates at all-ones.
- `sample_count` out 32: accepted samples since the last seed load; wraps modulo 2^32.
- `expected` out 64: model value (s0+s3) for the next sample.

## Operation
- **States.** The block has three states: IDLE, RUN and FAIL.
- **Reset.** Gives state=IDLE and model state=0. All outputs are 0.
- **Seed load.** Happens when `seed_valid`=1, in any state.
  - Nonzero seed: model←`seed`; state→RUN; `error`, `err_count`, `sample_count` and the consecutive-miss counter are cleared.
  - Zero seed: `seed_err` pulses; the state and model are unchanged.
- **Handshake.**
  - `in_ready` = (state==RUN) & ~`seed_valid`. This is a combinational path.
  - accept = `in_valid` & `in_ready`.
  - A sample presented while `in_ready`=0 is dropped, not stalled.
- **Compare on accept.**
  - Expected value = (s0+s3) mod 2^64, taken from the pre-update state.
  - The model then advances one step:
    1. t = s1<<17
    2. s2 ^= s0
    3. s3 ^= s1
    4. s1 ^= s2
    5. s0 ^= s3
    6. s2 ^= t
    7. s3 = rotl(s3,45)
  - The step uses sequential semantics: each line uses the results of the earlier lines.
  - `sample_count` increments by 1.
- **Mismatch.**
  - `mismatch` pulses, `error` sets, and `err_count` increments unless saturated.
  - The consecutive-miss counter increments.
  - When that counter reaches `MAX_MISS`, state→FAIL.
- **Match.** Clears the consecutive-miss counter.
- **FAIL.**
  - `in_ready`=0 and counters hold.
  - The state can be left only by a nonzero seed load or by `rst`.
- **Simultaneous events.**
  - `seed_valid` together with `in_valid`: the seed wins and the sample is not accepted.
  - `rst` overrides everything.

## Timing
- **Latency.** A sample accepted at edge N produces `mismatch`, `error`, `err_count` and `sample_count` updates visible after edge N. The `fail` transition is visible after the same edge.
- **`expected`.** Registered from the model state. It shows the next expected value from the cycle after a seed load onward.
- **Seed to RUN.** A seed loaded at edge N gives `locked`=1 and `in_ready`=1 from cycle N+1.
- **Throughput.** One sample per cycle with no bubbles; the model advances in a single cycle.
- **Reset mid-stream.** Takes effect at the next edge. Any sample in that cycle is discarded and the counters clear.

## Test plan
- **Known sequence.** Reset, then seed s0=1, s1=2, s2=3, s3=4, then feed 0x5 and 0x0000C00000000007 → `expected` shows 0x5 then 0x0000C00000000007; no `mismatch`; `sample_count`=2; `locked`=1.
- **Zero seed.** Seed 256'h0 after reset → `seed_err` pulses for one cycle; state stays IDLE; `in_ready`=0.
- **Single error.** Known seed, corrupt sample 3 (xor 0x1) → `mismatch` pulses once; `error`=1; `err_count`=1; a correct sample 4 keeps `locked`=1.
- **Loss of lock.** `MAX_MISS`=4, then 4 consecutive bad samples → `fail`=1 after the 4th; `in_ready`=0; `err_count`=4. Reseeding with 1/2/3/4 → `locked`=1 and counters at 0.
- **Seed/sample collision.** `seed_valid` and `in_valid` high together → sample not counted; model equals the new seed; `expected`=s0+s3 of the new seed.
- **Saturation and reset.** `CNT_W`=2 with 6 mismatches spread so that none are consecutive → `err_count`=3. Pulse `rst` mid-stream → every output is 0 on the next cycle.
